// File: rtl/harp_voice_mixer_pkg.sv
// harp_voice_mixer_pkg: shared constants, pitch table, FSM states and saturation helper for the harp mixer
package harp_pkg;
  localparam int NUM_VOICES_DEF = 8;
  localparam int AMP = 4096;
  localparam int ENV_STEP = 4;
  localparam logic [7:0][23:0] PHASE_INC = {
    24'd387529, 24'd345249, 24'd307582, 24'd258645,
    24'd230426, 24'd193764, 24'd172624, 24'd153791
  };
  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUTPUT} state_t;
  function automatic logic signed [15:0] sat16(input logic signed [18:0] x);
    return (x > 19'sd32767) ? 16'sh7fff : (x < -19'sd32768) ? 16'sh8000 : x[15:0];
  endfunction
endpackage

// File: rtl/harp_voice_mixer_if.sv
// harp_voice_mixer_if: valid/ready sample stream from the mixer to the audio core
interface harp_voice_mixer_if;
  logic signed [15:0] sample_data;
  logic sample_valid;
  logic sample_ready;
  modport master(output sample_data, output sample_valid, input sample_ready);
  modport slave(input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/harp_voice_mixer_debounce.sv
// harp_beam_debounce: two-flop synchronizer and consecutive-cycle debouncer for one laser beam
module harp_beam_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_beam,
  output logic o_active
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_active;
  // synchronize the beam, then accept a change only after it persists unbroken
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_active <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_beam};
      if (r_sync[1] == r_active) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_active <= r_sync[1];
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_active = r_active;
endmodule

// File: rtl/harp_voice_mixer.sv
// harp_voice_mixer: square-wave harp voices summed per sample tick; optional envelope via HARP_ENVELOPE_EN
module harp_voice_mixer
  import harp_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int PHASE_W = 24,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic [NUM_VOICES-1:0] beam_broken,
  harp_voice_mixer_if.master aud,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [7:0] overrun_cnt
);
  localparam int IDX_W = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  state_t r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  logic signed [18:0] r_acc;
  logic signed [15:0] r_data;
  logic [7:0] r_ovr;
  logic [PHASE_W-1:0] r_phase [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_gate;
  logic signed [18:0] w_contrib [NUM_VOICES];
  logic w_xfer, w_start, w_drop;
  assign w_xfer = aud.sample_valid && aud.sample_ready;
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_db
    harp_beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .i_beam(beam_broken[v]), .o_active(voice_active[v])
    );
  end
`ifdef HARP_ENVELOPE_EN
  logic [7:0] r_env [NUM_VOICES];
  logic signed [27:0] w_prod [NUM_VOICES];
  // envelope ramps once per sample tick toward 255 while held and toward 0 after release
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_VOICES; i++)
      if (reset) r_env[i] <= '0;
      else if (sample_tick)
        r_env[i] <= voice_active[i]
          ? (r_env[i] > 8'(255 - ENV_STEP) ? 8'd255 : r_env[i] + 8'(ENV_STEP))
          : (r_env[i] < 8'(ENV_STEP) ? 8'd0 : r_env[i] - 8'(ENV_STEP));
  end
  // a voice keeps sounding through its release tail; contribution is the square scaled by env/256
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_gate[i] = voice_active[i] || r_env[i] != 8'd0;
      w_prod[i] = $signed(28'(r_phase[i][PHASE_W-1] ? -AMP : AMP)) * $signed({20'd0, r_env[i]});
      w_contrib[i] = w_gate[i] ? 19'(w_prod[i] >>> 8) : 19'sd0;
    end
  end
`else
  // plain gate: full-amplitude square while the beam is broken, silence otherwise
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_gate[i] = voice_active[i];
      w_contrib[i] = !w_gate[i] ? 19'sd0 : r_phase[i][PHASE_W-1] ? -19'(AMP) : 19'(AMP);
    end
  end
`endif
  // silent voices sit at phase 0 so every note starts on its positive half; a voice advances in its slot
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_VOICES; i++)
      if (reset || !w_gate[i]) r_phase[i] <= '0;
      else if (r_state == ACCUM && r_idx == IDX_W'(i))
        r_phase[i] <= r_phase[i] + PHASE_W'(PHASE_INC[i]);
  end
  // state register
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  // next state plus start/drop strobes for the datapath and overrun counter
  always_comb begin
    w_next = r_state;
    w_start = 1'b0;
    w_drop = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_start = sample_tick;
        w_next = sample_tick ? ACCUM : IDLE;
      end
      ACCUM: begin
        w_drop = sample_tick;
        w_next = r_idx == IDX_W'(NUM_VOICES - 1) ? SCALE : ACCUM;
      end
      SCALE: begin
        w_drop = sample_tick;
        w_next = OUTPUT;
      end
      OUTPUT: begin
        w_start = sample_tick;
        w_drop = sample_tick && !w_xfer;
        w_next = sample_tick ? ACCUM : w_xfer ? IDLE : OUTPUT;
      end
      default: w_next = IDLE;
    endcase
  end
  // one voice summed per ACCUM cycle, saturated in SCALE, overruns counted up to 255
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
      r_acc <= '0;
      r_data <= '0;
      r_ovr <= '0;
    end else begin
      if (w_start) begin
        r_idx <= '0;
        r_acc <= '0;
      end else if (r_state == ACCUM) begin
        r_acc <= r_acc + w_contrib[r_idx];
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == SCALE) r_data <= sat16(r_acc);
      if (w_drop && r_ovr != 8'hff) r_ovr <= r_ovr + 1'b1;
    end
  end
  assign aud.sample_data = r_data;
  assign aud.sample_valid = r_state == OUTPUT;
  assign overrun_cnt = r_ovr;
endmodule

// File: tb/tb_harp_voice_mixer.sv
// tb_harp_voice_mixer: directed stimulus with a queue scoreboard checked on every sample transfer
module tb_harp_voice_mixer;
  localparam int DB = 20;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_tick = 1'b0;
  logic [7:0] beam_broken = '0;
  logic [7:0] voice_active;
  logic [7:0] overrun_cnt;
  int checks = 0;
  int failures = 0;
  int exp_q[$];
  harp_voice_mixer_if aud();
  harp_voice_mixer #(.NUM_VOICES(8), .PHASE_W(24), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .beam_broken(beam_broken),
    .aud(aud), .voice_active(voice_active), .overrun_cnt(overrun_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_tick();
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
  endtask
  task automatic send(input int exp, input int gap);
    exp_q.push_back(exp);
    pulse_tick();
    cyc(gap - 1);
  endtask
  always @(negedge clk) begin
    if (!reset && aud.sample_valid && aud.sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample: got %0d expected none at %0t", $signed(aud.sample_data), $time);
      end else check("sample", int'($signed(aud.sample_data)), exp_q.pop_front());
    end
  end
  initial begin
    int bad;
    aud.sample_ready = 1'b0;
    cyc(2);
    reset = 1'b0;
    check("reset_data", int'(aud.sample_data), 0);
    check("reset_valid", int'(aud.sample_valid), 0);
    check("reset_active", int'(voice_active), 0);
    check("reset_overrun", int'(overrun_cnt), 0);
    aud.sample_ready = 1'b1;
    beam_broken = 8'h01;
    cyc(DB + 5);
    check("v0_active", int'(voice_active), 1);
    exp_q.push_back(4096);
    pulse_tick();
    cyc(8);
    check("latency_low_t9", int'(aud.sample_valid), 0);
    cyc(1);
    check("latency_high_t10", int'(aud.sample_valid), 1);
    cyc(10);
    for (int k = 1; k <= 55; k++) send(k < 55 ? 4096 : -4096, 20);
    beam_broken = 8'h00;
    cyc(DB + 5);
    check("v0_released", int'(voice_active), 0);
    beam_broken = 8'hff;
    cyc(DB + 5);
    check("all_active", int'(voice_active), 255);
    send(32767, 20);
    beam_broken = 8'h00;
    cyc(DB + 5);
    beam_broken = 8'h08;
    cyc(DB - 1);
    beam_broken = 8'h00;
    cyc(3);
    check("short_pulse_active", int'(voice_active), 0);
    send(0, 20);
    check("short_pulse_after", int'(voice_active), 0);
    beam_broken = 8'h01;
    cyc(DB + 5);
    check("v0_reactive", int'(voice_active), 1);
    aud.sample_ready = 1'b0;
    pulse_tick();
    cyc(14);
    check("held_valid", int'(aud.sample_valid), 1);
    check("held_data", int'($signed(aud.sample_data)), 4096);
    cyc(3);
    check("held_data_stable", int'($signed(aud.sample_data)), 4096);
    check("no_overrun_yet", int'(overrun_cnt), 0);
    pulse_tick();
    check("drop_valid", int'(aud.sample_valid), 0);
    check("drop_overrun", int'(overrun_cnt), 1);
    aud.sample_ready = 1'b1;
    exp_q.push_back(4096);
    cyc(8);
    check("drop_latency_low", int'(aud.sample_valid), 0);
    cyc(1);
    check("drop_latency_high", int'(aud.sample_valid), 1);
    cyc(10);
    aud.sample_ready = 1'b0;
    sample_tick = 1'b1;
    cyc(400);
    sample_tick = 1'b0;
    check("overrun_saturate", int'(overrun_cnt), 255);
    cyc(20);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    check("rereset_overrun", int'(overrun_cnt), 0);
    aud.sample_ready = 1'b1;
    cyc(DB + 5);
    check("v0_after_reset", int'(voice_active), 1);
    pulse_tick();
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (aud.sample_valid) bad = 1;
    end
    check("no_valid_after_mid_reset", bad, 0);
    cyc(DB + 5);
    send(4096, 20);
    send(4096, 20);
    cyc(5);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
